ff_bank: RTL
============

# ff_bank

Parametrised multi-mode flip-flop register bank: WIDTH independent storage bits sharing one clock. Each cycle the bank behaves as a D, T, JK or SR flip-flop array according to a runtime mode input. It adds clock enable, per-bit edge flags, a sticky SR-conflict flag and a saturating change counter. It is the general-purpose state element for datapaths and control logic that previously instantiated single D or converted T flip-flops.

## Interface

Parameters:
- WIDTH, 8, number of storage bits (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset and at power-up
- CNT_W, 16, width of change counter (≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable; 0 = hold every bit
- mode  input  2  00 D, 01 T, 10 JK, 11 SR; sampled every edge
- a  input  WIDTH  D / T / J / S per bit
- b  input  WIDTH  K / R per bit; ignored in D and T modes
- clr_err  input  1  clears sr_err
- q  output  WIDTH  stored state
- qb  output  WIDTH  ~q, combinational from q
- rise  output  WIDTH  per-bit 0→1 flag for the current q
- fall  output  WIDTH  per-bit 1→0 flag for the current q
- sr_err  output  1  sticky: SR conflict seen
- chg_cnt  output  CNT_W  count of edges where q changed, saturating

## Operation

- Next-state per bit i, when en=1 and rst=0:
  - D: q_next = a[i]
  - T: q_next = q[i] ^ a[i]
  - JK: 00 hold, 01 clear, 10 set, 11 toggle (J = a[i], K = b[i])
  - SR: 00 hold, 10 set, 01 clear, 11 hold (the conflict state)
- en=0: q_next = q, with no edge flags, no counter increment and no error capture.
- rise[i] = ~q[i] & q_next[i] and fall[i] = q[i] & ~q_next[i]. Both are registered with q, so they describe the transition that produced the current q. Each is a one-cycle pulse unless q keeps changing.
- sr_err is set on an edge where en=1, mode=SR and (a & b) ≠ 0. Once set it stays set until clr_err=1 or rst=1. If a set condition and clr_err=1 occur on the same edge, set wins.
- chg_cnt increments by 1 on every edge where q_next ≠ q. The increment is one per edge, not one per changed bit. The counter saturates at 2^CNT_W−1 and does not wrap. clr_err has no effect on chg_cnt.
- Reset has priority over en, mode and clr_err. On reset: q=RESET_VAL, qb=~RESET_VAL, rise=0, fall=0, sr_err=0, chg_cnt=0. Reset does not count as a change.
- Before the first reset, q, qb and flags power up at the same reset values, via the initial value.
- A mode change takes effect on the same edge it is sampled. There is no pipeline and no state is carried between modes.

## Timing

- Latency is 1 cycle from inputs to q, rise, fall, sr_err and chg_cnt.
- qb has 0-cycle latency from q.
- Reset asserted mid-operation clears everything on that edge. With rst held, outputs stay at reset values. The first edge with rst=0 applies normal next-state.
- All outputs are registered except qb.

## Structure

- Package ff_bank_pkg holds the mode encodings MODE_D, MODE_T, MODE_JK and MODE_SR (2-bit localparams/typedef).
- Sub-module ff_cell: one bit with ports clk, rst, en, mode, a, b, rst_val. Outputs are q, rise, fall and conflict. The conflict output is combinational.
- The top level generates WIDTH ff_cell instances. It contains the OR-reduction for sr_err, the change detect (OR of rise | fall next-values) and the saturating counter.

## Test plan

- Reset and D mode: RESET_VAL=8'hA5. Drive rst=1 for 1 edge, then mode=D, a=8'h3C.
  - After reset: q=A5, qb=5A, chg_cnt=0.
  - Next edge: q=3C, rise=18, fall=81, chg_cnt=1.
- T mode and enable: q=00, mode=T, a=FF. Four edges with en=1,1,0,1 → q=FF, 00, 00, FF; chg_cnt=3.
- JK truth table: bit0 J/K = 00, 10, 01, 11, 11 from q=0 → q0 = 0, 1, 0, 1, 0.
- SR conflict: mode=SR, a=8'h01, b=8'h01, q=00 → q holds at 00 and sr_err=1. Then:
  - sr_err stays 1 through later valid cycles.
  - clr_err=1 together with a new conflict leaves it 1.
  - clr_err=1 alone clears it.
- Counter saturation: CNT_W=2, T mode, a=01 for 6 edges → chg_cnt = 1, 2, 3, 3, 3, 3.
- Reset mid-operation: rst=1 on an edge where en=1, mode=T and a=FF → q=RESET_VAL, rise=fall=0, chg_cnt=0, no increment.

Source files
------------

// File: rtl/ff_bank_pkg.sv
// Shared definitions for the multi-mode flip-flop bank.
// Holds the 2-bit mode encodings used by the bank and its per-bit cells.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

endpackage

// File: rtl/ff_cell.sv
// One storage bit of ff_bank: D/T/JK/SR next-state, registered edge flags,
// a combinational SR-conflict output and a combinational change strobe.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_rst_val,
  output logic       o_q,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_conflict,
  output logic       o_chg
);

  logic r_q    = INIT;
  logic r_rise = 1'b0;
  logic r_fall = 1'b0;
  logic w_q_next;

  always_comb begin
    w_q_next = r_q;
    if (i_en) begin
      unique case (mode_e'(i_mode))
        MODE_D:  w_q_next = i_a;
        MODE_T:  w_q_next = r_q ^ i_a;
        MODE_JK: begin
          unique case ({i_a, i_b})
            2'b01:   w_q_next = 1'b0;
            2'b10:   w_q_next = 1'b1;
            2'b11:   w_q_next = ~r_q;
            default: w_q_next = r_q;
          endcase
        end
        MODE_SR: begin
          // S=R=1 is the conflict state and holds
          unique case ({i_a, i_b})
            2'b01:   w_q_next = 1'b0;
            2'b10:   w_q_next = 1'b1;
            default: w_q_next = r_q;
          endcase
        end
        default: w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= i_rst_val;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_rise <= ~r_q & w_q_next;
      r_fall <= r_q & ~w_q_next;
    end
  end

  assign o_q        = r_q;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_conflict = i_en & (i_mode == MODE_SR) & i_a & i_b;
  assign o_chg      = r_q ^ w_q_next;

endmodule

// File: rtl/ff_bank.sv
// WIDTH-bit multi-mode flip-flop bank with clock enable, edge flags,
// a sticky SR-conflict flag and a saturating per-edge change counter.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned             WIDTH     = 8,
  parameter logic [WIDTH-1:0]        RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned             CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qb,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_sr_err,
  output logic [CNT_W-1:0] o_chg_cnt
);

  logic [WIDTH-1:0] w_conflict;
  logic [WIDTH-1:0] w_chg;
  logic             r_sr_err = 1'b0;
  logic [CNT_W-1:0] r_cnt    = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .INIT(RESET_VAL[i])
    ) u_cell (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_mode    (i_mode),
      .i_a       (i_a[i]),
      .i_b       (i_b[i]),
      .i_rst_val (RESET_VAL[i]),
      .o_q       (o_q[i]),
      .o_rise    (o_rise[i]),
      .o_fall    (o_fall[i]),
      .o_conflict(w_conflict[i]),
      .o_chg     (w_chg[i])
    );
  end

  // A new conflict outranks a simultaneous clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr_err <= 1'b0;
    end else if (|w_conflict) begin
      r_sr_err <= 1'b1;
    end else if (i_clr_err) begin
      r_sr_err <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if ((|w_chg) && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_qb      = ~o_q;
  assign o_sr_err  = r_sr_err;
  assign o_chg_cnt = r_cnt;

endmodule
